// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic phase sequencer.
//   - phase_e      : phase encoding (codes 6 and 7 are illegal)
//   - LIGHT_*      : lamp encodings {R,Y,G}, one-hot
//   - *_DEF        : default timing parameters
//   - next_phase   : fixed phase order, illegal codes recover to ALLRED_B
//   - load_from_dur: seconds-remaining load value, a duration of 0 counts as 1
package traffic_pkg;

  localparam int unsigned TICKS_PER_SEC_DEF = 10000;
  localparam int unsigned PED_GREEN_SEC_DEF = 5;
  localparam int unsigned SEC_W             = 8;
  localparam int unsigned PHASE_W           = 3;
  localparam int unsigned LIGHT_W           = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_NS_GREEN  = 3'd0,
    PH_NS_YELLOW = 3'd1,
    PH_ALLRED_A  = 3'd2,
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_ALLRED_B  = 3'd5
  } phase_e;

  localparam logic [LIGHT_W-1:0] LIGHT_R = 3'b100;
  localparam logic [LIGHT_W-1:0] LIGHT_Y = 3'b010;
  localparam logic [LIGHT_W-1:0] LIGHT_G = 3'b001;

  function automatic phase_e next_phase(input phase_e cur);
    case (cur)
      PH_NS_GREEN:  return PH_NS_YELLOW;
      PH_NS_YELLOW: return PH_ALLRED_A;
      PH_ALLRED_A:  return PH_EW_GREEN;
      PH_EW_GREEN:  return PH_EW_YELLOW;
      PH_EW_YELLOW: return PH_ALLRED_B;
      PH_ALLRED_B:  return PH_NS_GREEN;
      default:      return PH_ALLRED_B;
    endcase
  endfunction

  function automatic logic [SEC_W-1:0] load_from_dur(input logic [SEC_W-1:0] dur);
    return (dur == '0) ? '0 : dur - SEC_W'(1);
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// phase_timer: seconds timer for one phase.
//   CLK, reset     : clock, synchronous active-high reset
//   enable         : 1 = count, 0 = hold everything
//   load, load_val : restart the phase with load_val seconds left after the current one
//   clamp          : pedestrian shortening request (green phases only)
//   phase_done     : registered, high on the final cycle of the phase
//   sec_left       : whole seconds remaining after the current second
// TICKS_PER_SEC must be at least 2 so phase_done can be looked ahead by one edge.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int unsigned PED_GREEN_SEC = PED_GREEN_SEC_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  input  logic             clamp,
  output logic             phase_done,
  output logic [SEC_W-1:0] sec_left
);

  localparam int unsigned       TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam bit                CLAMP_OK  = (PED_GREEN_SEC > 0);
  localparam logic [SEC_W-1:0]  PED_SEC   = SEC_W'(PED_GREEN_SEC);
  localparam logic [SEC_W-1:0]  PED_LOAD  = SEC_W'(CLAMP_OK ? PED_GREEN_SEC - 1 : 0);

  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_nxt;
  logic [SEC_W-1:0]  sec_nxt;
  logic              done_nxt;

  // Next tick/second; phase_done is a lookahead of "next state is the final cycle".
  always_comb begin
    tick_nxt = tick_cnt;
    sec_nxt  = sec_left;
    done_nxt = phase_done;
    if (load) begin
      tick_nxt = '0;
      sec_nxt  = load_val;
    end else if (enable) begin
      if (tick_cnt == TICK_LAST) begin
        tick_nxt = '0;
        if (sec_left != '0) begin
          // Clamp only ever shortens: it applies when it would not add time.
          if (clamp && CLAMP_OK && (sec_left >= PED_SEC)) begin
            sec_nxt = PED_LOAD;
          end else begin
            sec_nxt = sec_left - SEC_W'(1);
          end
        end
      end else begin
        tick_nxt = tick_cnt + TICK_W'(1);
      end
    end
    // While frozen the flag holds, so it keeps tracking the held counters.
    if (load || enable) begin
      done_nxt = (tick_nxt == TICK_LAST) && (sec_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      tick_cnt   <= '0;
      sec_left   <= '0;
      phase_done <= 1'b0;
    end else begin
      tick_cnt   <= tick_nxt;
      sec_left   <= sec_nxt;
      phase_done <= done_nxt;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: steps the intersection through NS green, NS yellow,
// all-red, EW green, EW yellow, all-red, each held for a programmable number
// of seconds.
//   CLK, reset          : 10 kHz clock, synchronous active-high reset
//   enable              : 1 = run, 0 = freeze
//   ns_green_sec, ew_green_sec, yellow_sec, allred_sec : phase durations (s)
//   ped_req             : pedestrian request (level or pulse)
//   ns_light, ew_light  : {R,Y,G} one-hot, decoded from the phase register
//   phase               : current phase code
//   sec_left            : whole seconds remaining after the current second
//   phase_done          : high on the last cycle of each phase
// Build option: define PED_REQ_EN to latch ped_req and shorten the running
// green to PED_GREEN_SEC seconds; otherwise ped_req is ignored.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int unsigned PED_GREEN_SEC = PED_GREEN_SEC_DEF
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               enable,
  input  logic [SEC_W-1:0]   ns_green_sec,
  input  logic [SEC_W-1:0]   ew_green_sec,
  input  logic [3:0]         yellow_sec,
  input  logic [3:0]         allred_sec,
  input  logic               ped_req,
  output logic [LIGHT_W-1:0] ns_light,
  output logic [LIGHT_W-1:0] ew_light,
  output logic [PHASE_W-1:0] phase,
  output logic [SEC_W-1:0]   sec_left,
  output logic               phase_done
);

  phase_e           phase_q;
  phase_e           phase_nxt;
  phase_e           target;
  logic             load;
  logic [SEC_W-1:0] dur;
  logic [SEC_W-1:0] load_val;
  logic             clamp;

  // Phase register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      phase_q <= PH_ALLRED_B;
    end else begin
      phase_q <= phase_nxt;
    end
  end

  // Advance on the final cycle of a phase; illegal codes recover at once.
  always_comb begin
    phase_nxt = phase_q;
    load      = 1'b0;
    target    = next_phase(phase_q);
    if (enable && (phase_done || (phase_q > PH_ALLRED_B))) begin
      phase_nxt = target;
      load      = 1'b1;
    end
  end

  // Duration of the phase being entered, sampled only on the entry edge.
  always_comb begin
    dur = SEC_W'(allred_sec);
    case (target)
      PH_NS_GREEN:                dur = ns_green_sec;
      PH_EW_GREEN:                dur = ew_green_sec;
      PH_NS_YELLOW, PH_EW_YELLOW: dur = SEC_W'(yellow_sec);
      default:                    dur = SEC_W'(allred_sec);
    endcase
    load_val = load_from_dur(dur);
  end

`ifdef PED_REQ_EN
  logic ped_pending;
  logic ped_clear;

  // Entering either yellow consumes the request; clear beats a same-cycle set.
  assign ped_clear = load && ((phase_nxt == PH_NS_YELLOW) || (phase_nxt == PH_EW_YELLOW));

  always_ff @(posedge CLK) begin
    if (reset) begin
      ped_pending <= 1'b0;
    end else if (enable) begin
      ped_pending <= ped_clear ? 1'b0 : (ped_pending | ped_req);
    end
  end

  assign clamp = ped_pending && ((phase_q == PH_NS_GREEN) || (phase_q == PH_EW_GREEN));
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign clamp      = 1'b0;
`endif

  phase_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .PED_GREEN_SEC(PED_GREEN_SEC)
  ) u_timer (
    .CLK       (CLK),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .load_val  (load_val),
    .clamp     (clamp),
    .phase_done(phase_done),
    .sec_left  (sec_left)
  );

  assign phase = phase_q;

  // Lamp decode straight from the phase register: no intermediate states.
  always_comb begin
    ns_light = LIGHT_R;
    ew_light = LIGHT_R;
    case (phase_q)
      PH_NS_GREEN:  ns_light = LIGHT_G;
      PH_NS_YELLOW: ns_light = LIGHT_Y;
      PH_EW_GREEN:  ew_light = LIGHT_G;
      PH_EW_YELLOW: ew_light = LIGHT_Y;
      default:      ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with TICKS_PER_SEC=4, PED_GREEN_SEC=2.
module tb_traffic_phase_sequencer;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  logic       CLK;
  logic       reset;
  logic       enable;
  logic [7:0] ns_green_sec;
  logic [7:0] ew_green_sec;
  logic [3:0] yellow_sec;
  logic [3:0] allred_sec;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [7:0] sec_left;
  logic       phase_done;

  int tests;
  int fails;

  traffic_phase_sequencer #(
    .TICKS_PER_SEC(4),
    .PED_GREEN_SEC(2)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .enable      (enable),
    .ns_green_sec(ns_green_sec),
    .ew_green_sec(ew_green_sec),
    .yellow_sec  (yellow_sec),
    .allred_sec  (allred_sec),
    .ped_req     (ped_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .phase       (phase),
    .sec_left    (sec_left),
    .phase_done  (phase_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reset with the given durations; returns on the first cycle after release.
  task automatic apply_reset(input logic [7:0] ns, input logic [7:0] ew,
                             input logic [3:0] y, input logic [3:0] ar);
    @(negedge CLK);
    reset = 1'b1; enable = 1'b1; ped_req = 1'b0;
    ns_green_sec = ns; ew_green_sec = ew; yellow_sec = y; allred_sec = ar;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  // Sit in one phase from its first cycle, checking entry values, length and done pulse.
  task automatic measure(input logic [2:0] ph, input int len, input logic [7:0] sec0,
                         input logic [2:0] nsl, input logic [2:0] ewl, input string name);
    int cnt; int dones; int done_at;
    cnt = 0; dones = 0; done_at = -1;
    tests++;
    if (phase !== ph || sec_left !== sec0 || ns_light !== nsl || ew_light !== ewl) begin
      fails++;
      $display("FAIL %s entry: phase=%0d sec=%0d ns=%b ew=%b, want phase=%0d sec=%0d ns=%b ew=%b",
               name, phase, sec_left, ns_light, ew_light, ph, sec0, nsl, ewl);
    end
    while (phase === ph && cnt < 400) begin
      if (phase_done === 1'b1) begin dones++; done_at = cnt; end
      cnt++;
      @(negedge CLK);
    end
    tests++;
    if (cnt !== len) begin
      fails++;
      $display("FAIL %s length: got %0d cycles, want %0d", name, cnt, len);
    end
    tests++;
    if (dones !== 1 || done_at !== len - 1) begin
      fails++;
      $display("FAIL %s phase_done: %0d pulses, last at %0d, want 1 at %0d", name, dones, done_at, len - 1);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    reset = 1'b1; enable = 1'b1; ped_req = 1'b0;
    ns_green_sec = 8'd3; ew_green_sec = 8'd2; yellow_sec = 4'd1; allred_sec = 4'd1;
    repeat (2) @(negedge CLK);
    tests++;
    if (phase !== 3'd5 || ns_light !== L_R || ew_light !== L_R || sec_left !== 8'd0 || phase_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: phase=%0d ns=%b ew=%b sec=%0d done=%b, want 5 100 100 0 0",
               phase, ns_light, ew_light, sec_left, phase_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    measure(3'd5, 4,  8'd0, L_R, L_R, "seq_allred_b0");
    measure(3'd0, 12, 8'd2, L_G, L_R, "seq_ns_green");
    measure(3'd1, 4,  8'd0, L_Y, L_R, "seq_ns_yellow");
    measure(3'd2, 4,  8'd0, L_R, L_R, "seq_allred_a");
    measure(3'd3, 8,  8'd1, L_R, L_G, "seq_ew_green");
    measure(3'd4, 4,  8'd0, L_R, L_Y, "seq_ew_yellow");
    measure(3'd5, 4,  8'd0, L_R, L_R, "seq_allred_b1");
  endtask

  task automatic test_zero_duration();
    apply_reset(8'd0, 8'd1, 4'd1, 4'd1);
    measure(3'd5, 4, 8'd0, L_R, L_R, "zero_allred_b");
    measure(3'd0, 4, 8'd0, L_G, L_R, "zero_ns_green");
    measure(3'd1, 4, 8'd0, L_Y, L_R, "zero_ns_yellow");
  endtask

  task automatic test_freeze();
    int cnt; int dones; int done_at;
    apply_reset(8'd1, 8'd3, 4'd1, 4'd1);
    measure(3'd5, 4, 8'd0, L_R, L_R, "frz_allred_b");
    measure(3'd0, 4, 8'd0, L_G, L_R, "frz_ns_green");
    measure(3'd1, 4, 8'd0, L_Y, L_R, "frz_ns_yellow");
    measure(3'd2, 4, 8'd0, L_R, L_R, "frz_allred_a");
    cnt = 0; dones = 0; done_at = -1;
    while (phase === 3'd3 && cnt < 400) begin
      if (cnt == 5) begin
        tests++;
        if (sec_left !== 8'd1) begin
          fails++;
          $display("FAIL freeze_pre: sec_left=%0d, want 1", sec_left);
        end
      end
      if (cnt >= 6 && cnt <= 15) begin
        tests++;
        if (sec_left !== 8'd1 || ns_light !== L_R || ew_light !== L_G || phase_done !== 1'b0) begin
          fails++;
          $display("FAIL freeze_hold c%0d: sec=%0d ns=%b ew=%b done=%b, want 1 100 001 0",
                   cnt, sec_left, ns_light, ew_light, phase_done);
        end
      end
      if (phase_done === 1'b1) begin dones++; done_at = cnt; end
      if (cnt == 5)  enable = 1'b0;
      if (cnt == 15) enable = 1'b1;
      cnt++;
      @(negedge CLK);
    end
    tests++;
    if (cnt !== 22 || dones !== 1 || done_at !== 21) begin
      fails++;
      $display("FAIL freeze_length: len=%0d pulses=%0d at %0d, want 22 1 21", cnt, dones, done_at);
    end
    measure(3'd4, 4, 8'd0, L_R, L_Y, "frz_ew_yellow");
  endtask

  task automatic test_reset_mid();
    apply_reset(8'd1, 8'd1, 4'd3, 4'd1);
    measure(3'd5, 4, 8'd0, L_R, L_R, "rmid_allred_b");
    measure(3'd0, 4, 8'd0, L_G, L_R, "rmid_ns_green");
    repeat (5) @(negedge CLK);
    tests++;
    if (phase !== 3'd1 || sec_left !== 8'd1 || ns_light !== L_Y) begin
      fails++;
      $display("FAIL rmid_before: phase=%0d sec=%0d ns=%b, want 1 1 010", phase, sec_left, ns_light);
    end
    reset = 1'b1;
    @(negedge CLK);
    tests++;
    if (phase !== 3'd5 || ns_light !== L_R || ew_light !== L_R || sec_left !== 8'd0 || phase_done !== 1'b0) begin
      fails++;
      $display("FAIL rmid_after: phase=%0d ns=%b ew=%b sec=%0d done=%b, want 5 100 100 0 0",
               phase, ns_light, ew_light, sec_left, phase_done);
    end
    reset = 1'b0;
    measure(3'd5, 4, 8'd0, L_R, L_R, "rmid_restart");
  endtask

  task automatic test_duration_change();
    apply_reset(8'd3, 8'd1, 4'd1, 4'd1);
    measure(3'd5, 4, 8'd0, L_R, L_R, "dchg_allred_b");
    ns_green_sec = 8'd9;
    measure(3'd0, 12, 8'd2, L_G, L_R, "dchg_ns_green_old");
    measure(3'd1, 4,  8'd0, L_Y, L_R, "dchg_ns_yellow");
    measure(3'd2, 4,  8'd0, L_R, L_R, "dchg_allred_a");
    measure(3'd3, 4,  8'd0, L_R, L_G, "dchg_ew_green");
    measure(3'd4, 4,  8'd0, L_R, L_Y, "dchg_ew_yellow");
    measure(3'd5, 4,  8'd0, L_R, L_R, "dchg_allred_b2");
    measure(3'd0, 36, 8'd8, L_G, L_R, "dchg_ns_green_new");
  endtask

  task automatic test_ped();
    int cnt; int dones; int done_at;
    int exp_len; logic [7:0] exp_sec8;
`ifdef PED_REQ_EN
    exp_len = 16; exp_sec8 = 8'd1;
`else
    exp_len = 40; exp_sec8 = 8'd7;
`endif
    apply_reset(8'd10, 8'd3, 4'd1, 4'd1);
    measure(3'd5, 4, 8'd0, L_R, L_R, "ped_allred_b");
    cnt = 0; dones = 0; done_at = -1;
    while (phase === 3'd0 && cnt < 400) begin
      if (cnt == 4) begin
        tests++;
        if (sec_left !== 8'd8) begin
          fails++;
          $display("FAIL ped_pre: sec_left=%0d, want 8", sec_left);
        end
      end
      if (cnt == 8) begin
        tests++;
        if (sec_left !== exp_sec8) begin
          fails++;
          $display("FAIL ped_load: sec_left=%0d, want %0d", sec_left, exp_sec8);
        end
      end
      if (phase_done === 1'b1) begin dones++; done_at = cnt; end
      if (cnt == 4) ped_req = 1'b1;
      if (cnt == 5) ped_req = 1'b0;
      cnt++;
      @(negedge CLK);
    end
    tests++;
    if (cnt !== exp_len || dones !== 1 || done_at !== exp_len - 1) begin
      fails++;
      $display("FAIL ped_length: len=%0d pulses=%0d at %0d, want %0d 1 %0d",
               cnt, dones, done_at, exp_len, exp_len - 1);
    end
    measure(3'd1, 4,  8'd0, L_Y, L_R, "ped_ns_yellow");
    measure(3'd2, 4,  8'd0, L_R, L_R, "ped_allred_a");
    measure(3'd3, 12, 8'd2, L_R, L_G, "ped_ew_green_cleared");
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; enable = 1'b0; ped_req = 1'b0;
    ns_green_sec = '0; ew_green_sec = '0; yellow_sec = '0; allred_sec = '0;
    test_reset();
    test_sequence();
    test_zero_duration();
    test_freeze();
    test_reset_mid();
    test_duration_change();
    test_ped();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
